// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit indices, default widths and the
// default-width MEM/WB payload layout.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [CTRL_W-1:0] ctrl;
  } mmwb_payload_t;

endpackage

// File: rtl/mm_wb_stage_if.sv
// MEM/WB handshake bundle: memory-stage side (in_*) and writeback side (out_*).
interface mm_wb_stage_if #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_AW = pipe_pkg::REG_AW,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_y;
  logic [DATA_W-1:0] in_data;
  logic [REG_AW-1:0] in_dst;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [DATA_W-1:0] out_data;
  logic [REG_AW-1:0] out_dst;
  logic [REG_AW-1:0] out_rs;
  logic [REG_AW-1:0] out_rt;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_wdata;

  modport master (
    output in_valid, in_y, in_data, in_dst, in_rs, in_rt, in_ctrl, out_ready,
    input  in_ready, out_valid, out_y, out_data, out_dst, out_rs, out_rt,
           out_ctrl, out_wdata
  );

  modport slave (
    input  in_valid, in_y, in_data, in_dst, in_rs, in_rt, in_ctrl, out_ready,
    output in_ready, out_valid, out_y, out_data, out_dst, out_rs, out_rt,
           out_ctrl, out_wdata
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with synchronous flush. SKID=1 adds a
// second entry so in_ready is a register rather than a path from out_ready.
module pipe_skid_reg #(
  parameter int unsigned W    = 8,
  parameter int unsigned SKID = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         accept;
  logic         retire;

  assign accept    = in_valid & in_ready;
  assign retire    = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  if (SKID != 0) begin : g_skid
    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = reset & ~skid_valid;

    // Skid only fills while main is stalled, so it is always the younger entry.
    always_ff @(posedge clk) begin
      if (!reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || retire) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          if (accept) skid_data  <= in_data;
          else        skid_valid <= 1'b0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end else begin : g_direct
    assign in_ready = reset & (out_ready | ~main_valid);

    always_ff @(posedge clk) begin
      if (!reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else if (retire) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mm_wb_stage.sv
// MEM/WB stage register: handshaked payload register plus bubble squashing of
// the control bits and the writeback data select.
module mm_wb_stage #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_AW = pipe_pkg::REG_AW,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  mm_wb_stage_if.slave bus
);
  import pipe_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t in_pl;
  payload_t out_pl;
  logic     out_v;

  assign in_pl = '{y: bus.in_y, data: bus.in_data, dst: bus.in_dst,
                   rs: bus.in_rs, rt: bus.in_rt, ctrl: bus.in_ctrl};

  pipe_skid_reg #(
    .W    ($bits(payload_t)),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_pl),
    .out_valid (out_v),
    .out_ready (bus.out_ready),
    .out_data  (out_pl)
  );

  // Control is gated by valid so a bubble can never assert RegWrite.
  assign bus.out_valid = out_v;
  assign bus.out_y     = out_pl.y;
  assign bus.out_data  = out_pl.data;
  assign bus.out_dst   = out_pl.dst;
  assign bus.out_rs    = out_pl.rs;
  assign bus.out_rt    = out_pl.rt;
  assign bus.out_ctrl  = out_v ? out_pl.ctrl : '0;
  assign bus.out_wdata = bus.out_ctrl[CTRL_MEMTOREG] ? out_pl.data : out_pl.y;

endmodule

// File: tb/tb_mm_wb_stage.sv
// Bench for mm_wb_stage: SKID=1 and SKID=0 builds driven with the same stimulus,
// each compared against a bounded-FIFO reference model.
module tb_mm_wb_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mm_wb_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) bus1 ();
  mm_wb_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) bus0 ();

  mm_wb_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus1));
  mm_wb_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus0));

  mmwb_payload_t q1[$];
  mmwb_payload_t q0[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic mmwb_payload_t mk(input logic [31:0] y, input logic [31:0] data,
                                       input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [1:0] ctrl);
    mmwb_payload_t p;
    p.y = y; p.data = data; p.dst = dst; p.rs = rs; p.rt = rt; p.ctrl = ctrl;
    return p;
  endfunction

  task automatic chk_dut(input string tag, input logic exp_rdy, input logic exp_v,
                         input mmwb_payload_t e, input logic rdy, input logic v,
                         input mmwb_payload_t o, input logic [31:0] wd);
    chk({tag, " in_ready"},  64'(rdy), 64'(exp_rdy));
    chk({tag, " out_valid"}, 64'(v),   64'(exp_v));
    if (exp_v) begin
      chk({tag, " out_y"},    64'(o.y),    64'(e.y));
      chk({tag, " out_data"}, 64'(o.data), 64'(e.data));
      chk({tag, " out_dst"},  64'(o.dst),  64'(e.dst));
      chk({tag, " out_rs"},   64'(o.rs),   64'(e.rs));
      chk({tag, " out_rt"},   64'(o.rt),   64'(e.rt));
      chk({tag, " out_ctrl"}, 64'(o.ctrl), 64'(e.ctrl));
      chk({tag, " out_wdata"}, 64'(wd), 64'(e.ctrl[CTRL_MEMTOREG] ? e.data : e.y));
    end else begin
      chk({tag, " bubble ctrl"}, 64'(o.ctrl), 64'(0));
    end
  endtask

  // One clock: drive at edge+1, check before the next edge, update models at the edge.
  task automatic step(input logic iv, input mmwb_payload_t p, input logic ordy, input logic fl);
    logic r1, r0, rst_n;
    mmwb_payload_t f1, f0, o1, o0;
    bus1.in_valid = iv; bus1.in_y = p.y; bus1.in_data = p.data; bus1.in_dst = p.dst;
    bus1.in_rs = p.rs; bus1.in_rt = p.rt; bus1.in_ctrl = p.ctrl; bus1.out_ready = ordy;
    bus0.in_valid = iv; bus0.in_y = p.y; bus0.in_data = p.data; bus0.in_dst = p.dst;
    bus0.in_rs = p.rs; bus0.in_rt = p.rt; bus0.in_ctrl = p.ctrl; bus0.out_ready = ordy;
    flush = fl;
    #3;
    r1 = reset && (q1.size() < 2);
    r0 = reset && (ordy || q0.size() == 0);
    f1 = '0; f0 = '0;
    if (q1.size() > 0) f1 = q1[0];
    if (q0.size() > 0) f0 = q0[0];
    o1 = mk(bus1.out_y, bus1.out_data, bus1.out_dst, bus1.out_rs, bus1.out_rt, bus1.out_ctrl);
    o0 = mk(bus0.out_y, bus0.out_data, bus0.out_dst, bus0.out_rs, bus0.out_rt, bus0.out_ctrl);
    chk_dut("skid1", r1, q1.size() > 0, f1, bus1.in_ready, bus1.out_valid, o1, bus1.out_wdata);
    chk_dut("skid0", r0, q0.size() > 0, f0, bus0.in_ready, bus0.out_valid, o0, bus0.out_wdata);
    rst_n = reset;
    @(posedge clk);
    if (!rst_n || fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (iv && r1) q1.push_back(p);
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (iv && r0) q0.push_back(p);
    end
    #1;
  endtask

  initial begin
    mmwb_payload_t nop, pa, pb, pc, rp;
    logic riv, rordy, rfl;
    nop = mk(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00);
    pa  = mk(32'hA, 32'h100, 5'd1, 5'd2, 5'd3, 2'b01);
    pb  = mk(32'hB, 32'h200, 5'd4, 5'd5, 5'd6, 2'b01);
    pc  = mk(32'hC, 32'h300, 5'd7, 5'd8, 5'd9, 2'b11);

    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a live input present
    step(1'b1, mk(32'hDEADBEEF, 32'h1, 5'd1, 5'd1, 5'd1, 2'b11), 1'b0, 1'b0);
    step(1'b1, mk(32'hDEADBEEF, 32'h1, 5'd1, 5'd1, 5'd1, 2'b11), 1'b0, 1'b0);
    chk("rst out_y", 64'(bus1.out_y), 64'(0));
    chk("rst out_data", 64'(bus1.out_data), 64'(0));
    chk("rst out_dst", 64'(bus1.out_dst), 64'(0));
    chk("rst out_ctrl", 64'(bus1.out_ctrl), 64'(0));
    chk("rst out_wdata", 64'(bus1.out_wdata), 64'(0));
    chk("rst in_ready", 64'(bus1.in_ready), 64'(0));
    chk("rst in_ready skid0", 64'(bus0.in_ready), 64'(0));
    reset = 1'b1;
    #1;
    chk("release in_ready", 64'(bus1.in_ready), 64'(1));
    chk("release out_valid", 64'(bus1.out_valid), 64'(0));
    step(1'b0, nop, 1'b1, 1'b0);

    // Streaming at full rate
    step(1'b1, mk(32'd1, 32'h55, 5'd1, 5'd2, 5'd3, 2'b01), 1'b1, 1'b0);
    chk("stream y1", 64'(bus1.out_y), 64'(1));
    step(1'b1, mk(32'd2, 32'h55, 5'd1, 5'd2, 5'd3, 2'b01), 1'b1, 1'b0);
    chk("stream y2", 64'(bus1.out_y), 64'(2));
    chk("stream wdata2", 64'(bus1.out_wdata), 64'(2));
    step(1'b1, mk(32'd3, 32'h55, 5'd1, 5'd2, 5'd3, 2'b01), 1'b1, 1'b0);
    chk("stream y3", 64'(bus1.out_y), 64'(3));
    chk("stream in_ready", 64'(bus1.in_ready), 64'(1));

    // Load select
    step(1'b1, mk(32'h10, 32'hCAFE0000, 5'd4, 5'd7, 5'd9, 2'b11), 1'b1, 1'b0);
    chk("load wdata", 64'(bus1.out_wdata), 64'hCAFE0000);
    chk("load ctrl", 64'(bus1.out_ctrl), 64'(3));
    chk("load rs", 64'(bus1.out_rs), 64'(7));
    chk("load rt", 64'(bus1.out_rt), 64'(9));
    step(1'b0, nop, 1'b1, 1'b0);

    // Backpressure into the skid entry
    step(1'b1, pa, 1'b0, 1'b0);
    chk("bp hold A", 64'(bus1.out_y), 64'hA);
    step(1'b1, pb, 1'b0, 1'b0);
    chk("bp ready low", 64'(bus1.in_ready), 64'(0));
    chk("bp still A", 64'(bus1.out_y), 64'hA);
    step(1'b1, pc, 1'b0, 1'b0);
    step(1'b1, pc, 1'b0, 1'b0);
    chk("bp A stable", 64'(bus1.out_y), 64'hA);
    step(1'b1, pc, 1'b1, 1'b0);
    chk("bp then B", 64'(bus1.out_y), 64'hB);
    step(1'b1, pc, 1'b1, 1'b0);
    chk("bp then C", 64'(bus1.out_y), 64'hC);
    step(1'b0, nop, 1'b1, 1'b0);
    chk("bp drained", 64'(bus1.out_valid), 64'(0));

    // Flush with both entries occupied and a new input presented
    step(1'b1, pa, 1'b0, 1'b0);
    step(1'b1, pb, 1'b0, 1'b0);
    step(1'b1, pc, 1'b0, 1'b1);
    chk("flush out_valid", 64'(bus1.out_valid), 64'(0));
    chk("flush out_ctrl", 64'(bus1.out_ctrl), 64'(0));
    chk("flush in_ready", 64'(bus1.in_ready), 64'(1));
    step(1'b0, nop, 1'b1, 1'b0);
    chk("flush C dropped", 64'(bus1.out_valid), 64'(0));

    // Combinational ready of the SKID=0 build
    step(1'b1, mk(32'hD, 32'h0, 5'd1, 5'd1, 5'd1, 2'b01), 1'b0, 1'b0);
    chk("skid0 held ready", 64'(bus0.in_ready), 64'(0));
    bus0.out_ready = 1'b1;
    #1;
    chk("skid0 comb ready", 64'(bus0.in_ready), 64'(1));
    step(1'b1, mk(32'hE, 32'h0, 5'd1, 5'd1, 5'd1, 2'b01), 1'b1, 1'b0);
    chk("skid0 replaced", 64'(bus0.out_y), 64'hE);
    step(1'b0, nop, 1'b1, 1'b0);
    step(1'b0, nop, 1'b1, 1'b0);

    // Randomized traffic with occasional flush and mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rp = mk($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom));
      riv   = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 2) != 0);
      rfl   = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) != 0);
      step(riv, rp, rordy, rfl);
    end
    reset = 1'b1;
    step(1'b0, nop, 1'b1, 1'b0);
    step(1'b0, nop, 1'b1, 1'b0);
    step(1'b0, nop, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mm_wb_stage.md
Name: mm_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage register. Carries ALU result, load data, destination register and control bits from the memory stage to writeback.
- Adds what the fixed 32-bit stage lacks:
  - valid/ready handshake
  - optional 2-entry skid buffer, so backpressure does not create a combinational ready path
  - synchronous flush
  - bubble squashing: control bits are forced to 0 whenever the output is invalid.
- Sits between the memory stage and the register-file write port. The forwarding unit reads the out_* signals.

Parameters:
- DATA_W, 32, width of ALU result and load data
- REG_AW, 5, register-address width (dst, rs, rt)
- CTRL_W, 2, control bits; bit0 = RegWrite, bit1 = MemtoReg
- SKID, 1, 1 = registered in_ready with skid entry; 0 = single register, combinational in_ready

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_y  in  DATA_W  ALU result
- in_data  in  DATA_W  load data
- in_dst  in  REG_AW  destination register
- in_rs  in  REG_AW  source register rs
- in_rt  in  REG_AW  source register rt
- in_ctrl  in  CTRL_W  control bits
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback consumes entry
- out_y  out  DATA_W  registered ALU result
- out_data  out  DATA_W  registered load data
- out_dst  out  REG_AW  registered destination
- out_rs  out  REG_AW  registered rs (true copy of input; no self-hold)
- out_rt  out  REG_AW  registered rt (true copy of input)
- out_ctrl  out  CTRL_W  registered control; 0 whenever out_valid = 0
- out_wdata  out  DATA_W  combinational writeback mux: out_ctrl[1] ? out_data : out_y

Behaviour:
- Reset: reset sampled low at posedge clk.
  - Main and skid entries cleared: valid = 0, all payload = 0.
  - out_* = 0, out_wdata = 0.
  - in_ready = 0 while reset is low; in_ready = 1 in the first cycle after reset is released.
- Handshake:
  - Accept when in_valid & in_ready.
  - Retire when out_valid & out_ready.
  - Payload is stable while out_valid = 1 and out_ready = 0.
- Latency: 1 cycle input-to-output when not stalled.
- SKID = 1: in_ready = ~skid_valid (registered). Per clock, priority order:
  1. Flush: main_valid = 0, skid_valid = 0, out_ctrl = 0. Any input accepted this cycle is dropped. Payload registers may retain stale values, but out_ctrl is zeroed.
  2. Main empty or retiring:
     - skid_valid = 1: main <= skid; skid <= input if accepted, else skid_valid <= 0.
     - skid_valid = 0: main <= input if accepted, else main_valid <= 0 and out_ctrl <= 0.
  3. Main full and not retiring, input accepted: skid <= input, skid_valid <= 1.
  4. Otherwise hold.
- SKID = 0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Main loads when accepted; clears (valid = 0, ctrl = 0) when retiring with no accept.
  - No skid storage is instantiated.
- Ordering: strict FIFO. The skid entry always retires after the main entry.
- Bubble rule: out_ctrl is never nonzero with out_valid = 0, so RegWrite is never asserted on a bubble.
- Simultaneous cases:
  - Retire and accept in the same cycle keeps full throughput of 1 per cycle.
  - Flush together with reset low: reset wins; result is identical.
  - Reset asserted mid-stall discards both entries.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_REGWRITE = 0, CTRL_MEMTOREG = 1 bit indices
  - default widths DATA_W, REG_AW
  - packed struct mmwb_payload_t {y, data, dst, rs, rt, ctrl}
- One natural sub-module: pipe_skid_reg, a generic payload-width valid/ready register with flush.
  - mm_wb_stage instantiates it with the packed payload.
  - mm_wb_stage adds the bubble squash and the out_wdata mux.

Test Plan:
- Reset: reset = 0 for 2 cycles with in_valid = 1, in_y = 0xDEADBEEF -> all out_* = 0, in_ready = 0. First cycle after release: in_ready = 1, out_valid = 0.
- Streaming: out_ready = 1, inputs y = 1, 2, 3 on consecutive cycles, ctrl = 2'b01 -> out_y = 1, 2, 3 exactly one cycle later each. out_wdata = out_y. in_ready stays 1.
- Load select: in_ctrl = 2'b11, in_y = 0x10, in_data = 0xCAFE0000 -> out_wdata = 0xCAFE0000, out_ctrl = 2'b11. out_rs/out_rt equal the driven in_rs = 7, in_rt = 9.
- Backpressure (SKID = 1): hold out_ready = 0, send A = 0xA then B = 0xB.
  - out_y stays 0xA.
  - in_ready falls to 0 the cycle after B is accepted.
  - C = 0xC is held off.
  - Release out_ready -> output sequence A, B, C, with no loss or duplication.
- Flush: with A in main and B in skid, pulse flush for 1 cycle while C is presented -> next cycle out_valid = 0, out_ctrl = 0, in_ready = 1. C does not appear.
- SKID = 0 build: out_ready = 0 with one entry held -> in_ready = 0 in the same cycle. Raising out_ready combinationally raises in_ready, and the held entry is replaced next cycle.
